// File: rtl/t05_pkg.sv
// Shared types and constants for the byte-histogram accumulator.
package t05_pkg;

  localparam int          HIST_BINS = 256;
  localparam logic [31:0] CNT_MAX   = 32'hFFFF_FFFF;

  typedef enum logic [3:0] {
    S_IDLE,
    S_CLR_REQ,
    S_CLR_WAIT,
    S_GET,
    S_RD_REQ,
    S_RD_WAIT,
    S_WR_REQ,
    S_WR_WAIT,
    S_DONE
  } hist_state_t;

  // Saturating +1 used for the byte total; the counter sticks at all-ones.
  function automatic logic [31:0] sat_inc(input logic [31:0] v);
    return (v == CNT_MAX) ? v : v + 32'd1;
  endfunction

endpackage

// File: rtl/t05_sram_txn.sv
// One SRAM transaction handshake: raise the request, hold it until the
// interface reports busy, then flag completion on the cycle busy drops.
module t05_sram_txn (
  input  logic clk,
  input  logic rst,
  input  logic i_go,
  input  logic i_busy,
  output logic o_req,
  output logic o_acc,
  output logic o_done
);

  logic r_req;
  logic r_seen;

  // Request is held until the first busy cycle, then busy is tracked to its fall.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_req  <= 1'b0;
      r_seen <= 1'b0;
    end else begin
      if (i_go)
        r_req <= 1'b1;
      else if (r_req && i_busy)
        r_req <= 1'b0;

      if (r_req && i_busy)
        r_seen <= 1'b1;
      else if (r_seen && !i_busy)
        r_seen <= 1'b0;
    end
  end

  // Accept is the busy rise seen while requesting; done is the busy fall after it.
  always_comb begin
    o_req  = r_req;
    o_acc  = r_req & i_busy;
    o_done = r_seen & ~i_busy;
  end

endmodule

// File: rtl/t05_histogram_accum.sv
// Byte-frequency histogram: clears every bin in SRAM, then does one
// read-modify-write per accepted byte, with saturating counters.
module t05_histogram_accum
  import t05_pkg::*;
#(
  parameter int NUM_BINS = HIST_BINS,
  parameter int CNT_W    = 32
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic             in_valid,
  input  logic [7:0]       in_data,
  input  logic             in_last,
  output logic             in_ready,
  output logic [CNT_W-1:0] histogram,
  output logic [7:0]       histgram_addr,
  output logic             hist_r_wr,
  output logic             sram_req,
  input  logic             sram_busy,
  input  logic [CNT_W-1:0] old_char,
  output logic [31:0]      total,
  output logic             hist_done,
  output logic             hist_busy
);

  localparam logic [7:0]       LAST_IDX = 8'(NUM_BINS - 1);
  localparam logic [CNT_W-1:0] BIN_MAX  = {CNT_W{1'b1}};
  localparam logic [CNT_W-1:0] BIN_ONE  = {{(CNT_W-1){1'b0}}, 1'b1};

  hist_state_t      r_state, w_next;
  logic [7:0]       r_clr_idx;
  logic [7:0]       r_addr;
  logic [CNT_W-1:0] r_hist;
  logic             r_wr;
  logic             r_last;
  logic [31:0]      r_total;
  logic             w_go, w_acc, w_done;

  t05_sram_txn u_txn (
    .clk    (clk),
    .rst    (rst),
    .i_go   (w_go),
    .i_busy (sram_busy),
    .o_req  (sram_req),
    .o_acc  (w_acc),
    .o_done (w_done)
  );

  // State register.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) r_state <= S_IDLE;
    else      r_state <= w_next;
  end

  // Next state; w_go fires on every transition into a request state.
  always_comb begin
    w_next = r_state;
    w_go   = 1'b0;
    case (r_state)
      S_IDLE:     if (start) begin w_next = S_CLR_REQ; w_go = 1'b1; end
      S_CLR_REQ:  if (w_acc) w_next = S_CLR_WAIT;
      S_CLR_WAIT: if (w_done) begin
                    if (r_clr_idx == LAST_IDX) w_next = S_GET;
                    else begin w_next = S_CLR_REQ; w_go = 1'b1; end
                  end
      S_GET:      if (in_valid) begin w_next = S_RD_REQ; w_go = 1'b1; end
      S_RD_REQ:   if (w_acc) w_next = S_RD_WAIT;
      S_RD_WAIT:  if (w_done) begin w_next = S_WR_REQ; w_go = 1'b1; end
      S_WR_REQ:   if (w_acc) w_next = S_WR_WAIT;
      S_WR_WAIT:  if (w_done) w_next = r_last ? S_DONE : S_GET;
      S_DONE:     w_next = S_IDLE;
      default:    w_next = S_IDLE;
    endcase
  end

  // Transaction fields are loaded only at phase boundaries, so they stay
  // stable for the full request/busy window.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_clr_idx <= '0;
      r_addr    <= '0;
      r_hist    <= '0;
      r_wr      <= 1'b0;
      r_last    <= 1'b0;
      r_total   <= '0;
    end else begin
      case (r_state)
        S_IDLE: if (start) begin
          r_clr_idx <= '0;
          r_addr    <= '0;
          r_hist    <= '0;
          r_wr      <= 1'b1;
          r_total   <= '0;
        end
        S_CLR_WAIT: if (w_done && r_clr_idx != LAST_IDX) begin
          r_clr_idx <= r_clr_idx + 8'd1;
          r_addr    <= r_clr_idx + 8'd1;
        end
        S_GET: if (in_valid) begin
          r_addr  <= in_data;
          r_last  <= in_last;
          r_wr    <= 1'b0;
          r_total <= sat_inc(r_total);
        end
        S_RD_WAIT: if (w_done) begin
          r_hist <= (old_char == BIN_MAX) ? old_char : old_char + BIN_ONE;
          r_wr   <= 1'b1;
        end
        default: ;
      endcase
    end
  end

  // Status outputs decoded from state; SRAM fields straight from registers.
  always_comb begin
    in_ready      = (r_state == S_GET);
    hist_busy     = (r_state != S_IDLE);
    hist_done     = (r_state == S_DONE);
    histogram     = r_hist;
    histgram_addr = r_addr;
    hist_r_wr     = r_wr;
    total         = r_total;
  end

endmodule

// File: tb/tb_t05_histogram_accum.sv
// Directed bench for t05_histogram_accum with a behavioural SRAM interface.
module tb_t05_histogram_accum;

  logic        clk = 1'b0;
  logic        rst;
  logic        start;
  logic        in_valid;
  logic [7:0]  in_data;
  logic        in_last;
  logic        in_ready;
  logic [31:0] histogram;
  logic [7:0]  histgram_addr;
  logic        hist_r_wr;
  logic        sram_req;
  logic        sram_busy;
  logic [31:0] rdata = 32'd0;
  logic [31:0] total;
  logic        hist_done;
  logic        hist_busy;

  int n_vec = 0;
  int n_bad = 0;

  always #5 clk = ~clk;

  t05_histogram_accum dut (
    .clk           (clk),
    .rst           (rst),
    .start         (start),
    .in_valid      (in_valid),
    .in_data       (in_data),
    .in_last       (in_last),
    .in_ready      (in_ready),
    .histogram     (histogram),
    .histgram_addr (histgram_addr),
    .hist_r_wr     (hist_r_wr),
    .sram_req      (sram_req),
    .sram_busy     (sram_busy),
    .old_char      (rdata),
    .total         (total),
    .hist_done     (hist_done),
    .hist_busy     (hist_busy)
  );

  // SRAM interface model: busy rises with the request, lasts blen cycles,
  // and is not affected by the accumulator's reset.
  logic [31:0] mem [256];
  int   blen = 3;
  int   bcnt = 0;
  int   n_wr = 0, n_rd = 0, n_rise = 0;
  logic prev_req = 1'b0;
  int   cyc = 0;
  int   n_done = 0, done_cyc = 0;

  assign sram_busy = (bcnt != 0) || sram_req;

  always @(posedge clk) begin
    cyc      <= cyc + 1;
    prev_req <= sram_req;
    if (sram_req && !prev_req) n_rise <= n_rise + 1;
    if (bcnt != 0) bcnt <= bcnt - 1;
    else if (sram_req) begin
      bcnt <= blen - 1;
      if (hist_r_wr) begin
        mem[histgram_addr] = histogram;
        n_wr <= n_wr + 1;
      end else begin
        rdata <= mem[histgram_addr];
        n_rd  <= n_rd + 1;
      end
    end
  end

  always @(negedge clk) begin
    if (hist_done) begin
      n_done   <= n_done + 1;
      done_cyc <= cyc;
    end
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_vec++;
    assert (obs === exp) else begin
      n_bad++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic chk_reset(input string p);
    chk({p, "_in_ready"},  32'(in_ready),      32'd0);
    chk({p, "_sram_req"},  32'(sram_req),      32'd0);
    chk({p, "_hist_done"}, 32'(hist_done),     32'd0);
    chk({p, "_hist_busy"}, 32'(hist_busy),     32'd0);
    chk({p, "_histogram"}, histogram,          32'd0);
    chk({p, "_addr"},      32'(histgram_addr), 32'd0);
    chk({p, "_total"},     total,              32'd0);
    chk({p, "_r_wr"},      32'(hist_r_wr),     32'd0);
  endtask

  task automatic pulse_start();
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
  endtask

  task automatic wait_ready();
    int t = 0;
    while (!in_ready && t < 5000) begin @(negedge clk); t++; end
    if (!in_ready) chk("wait_ready_timeout", 32'(in_ready), 32'd1);
  endtask

  // Present one byte, wait for GET, record the handshake cycle.
  task automatic send(input logic [7:0] d, input logic l, output int hs);
    in_valid = 1'b1; in_data = d; in_last = l;
    wait_ready();
    hs = cyc;
    @(posedge clk);
    @(negedge clk);
    in_valid = 1'b0; in_last = 1'b0;
  endtask

  task automatic wait_done(input int d0);
    int t = 0;
    while (n_done == d0 && t < 5000) begin @(negedge clk); t++; end
    if (n_done == d0) chk("wait_done_timeout", 32'(n_done), 32'(d0 + 1));
    @(negedge clk);
  endtask

  task automatic wait_sram_idle();
    int t = 0;
    while (sram_busy && t < 100) begin @(negedge clk); t++; end
  endtask

  task automatic fill_garbage();
    for (int i = 0; i < 256; i++) mem[i] = 32'hDEAD_0000 + 32'(i);
  endtask

  function automatic int count_nonzero();
    int n = 0;
    for (int i = 0; i < 256; i++) if (mem[i] != 32'd0) n++;
    return n;
  endfunction

  initial begin
    int hs, stall, wr0, rd0, rise0, d0;
    rst = 1'b0; start = 1'b0; in_valid = 1'b0; in_data = 8'h00; in_last = 1'b0;
    fill_garbage();
    repeat (3) @(negedge clk);
    chk_reset("por");
    rst = 1'b1;
    @(negedge clk);

    // Stream 41,41,42 with in_valid held high through the clear, plus a
    // stray start pulse mid-clear that must be ignored.
    wr0 = n_wr; rd0 = n_rd; rise0 = n_rise; d0 = n_done;
    in_valid = 1'b1; in_data = 8'h41; in_last = 1'b0;
    pulse_start();
    stall = 0;
    while (!in_ready && stall < 3000) begin
      if (hist_busy) stall++;
      start = (stall == 500);
      @(negedge clk);
    end
    start = 1'b0;
    chk("clr_stall_cycles", 32'(stall), 32'd1024);
    chk("clr_writes", 32'(n_wr - wr0), 32'd256);
    chk("clr_nonzero_bins", 32'(count_nonzero()), 32'd0);
    send(8'h41, 1'b0, hs);
    send(8'h41, 1'b0, hs);
    send(8'h42, 1'b1, hs);
    wait_done(d0);
    chk("bin41", mem[8'h41], 32'd2);
    chk("bin42", mem[8'h42], 32'd1);
    chk("total3", total, 32'd3);
    chk("done_pulses", 32'(n_done - d0), 32'd1);
    chk("reads3", 32'(n_rd - rd0), 32'd3);
    chk("one_txn_per_req", 32'(n_rise - rise0), 32'((n_wr - wr0) + (n_rd - rd0)));
    chk("idle_after_done", 32'(hist_busy), 32'd0);

    // Reset while the read of the byte is in flight.
    pulse_start();
    wait_ready();
    send(8'h10, 1'b0, hs);
    @(negedge clk);
    rst = 1'b0;
    #1;
    chk_reset("midrd");
    @(negedge clk);
    @(negedge clk);
    rst = 1'b1;
    wait_sram_idle();
    @(negedge clk);

    // Fresh clear overwrites garbage, then a preloaded saturated bin.
    fill_garbage();
    wr0 = n_wr; d0 = n_done;
    pulse_start();
    wait_ready();
    chk("clr2_writes", 32'(n_wr - wr0), 32'd256);
    chk("clr2_nonzero_bins", 32'(count_nonzero()), 32'd0);
    mem[7] = 32'hFFFF_FFFF;
    send(8'h07, 1'b1, hs);
    wait_done(d0);
    chk("bin07_sat", mem[7], 32'hFFFF_FFFF);
    chk("sat_write_data", histogram, 32'hFFFF_FFFF);
    chk("total_sat_run", total, 32'd1);

    // Extended busy: each request still maps to exactly one transaction.
    blen = 5;
    wr0 = n_wr; rd0 = n_rd; rise0 = n_rise; d0 = n_done;
    pulse_start();
    wait_ready();
    chk("clr5_writes", 32'(n_wr - wr0), 32'd256);
    send(8'h05, 1'b0, hs);
    send(8'h05, 1'b0, hs);
    send(8'h06, 1'b1, hs);
    wait_done(d0);
    chk("b5_bin05", mem[8'h05], 32'd2);
    chk("b5_bin06", mem[8'h06], 32'd1);
    chk("b5_total", total, 32'd3);
    chk("b5_reads", 32'(n_rd - rd0), 32'd3);
    chk("b5_writes", 32'(n_wr - wr0), 32'd259);
    chk("b5_one_txn_per_req", 32'(n_rise - rise0), 32'((n_wr - wr0) + (n_rd - rd0)));

    // Single last byte at nominal busy: done nine cycles after handshake.
    blen = 3;
    d0 = n_done;
    pulse_start();
    wait_ready();
    send(8'hFF, 1'b1, hs);
    wait_done(d0);
    chk("ff_latency", 32'(done_cyc - hs), 32'd9);
    chk("bin_ff", mem[8'hFF], 32'd1);
    chk("ff_total", total, 32'd1);
    chk("ff_done_pulses", 32'(n_done - d0), 32'd1);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

endmodule

// File: doc/t05_histogram_accum.md
# t05_histogram_accum

Upstream stage of the SRAM interface in the compression pipeline. Clears 256 bins of byte-frequency counters in SRAM, then consumes an input byte stream and performs one read-modify-write per byte through the SRAM interface's HIST path. Signals completion to the controller so FLV can start. Counters saturate, never wrap.

## Interface
Parameters:
- `NUM_BINS`, 256: number of histogram bins, one per byte value.
- `CNT_W`, 32: counter width, matching the SRAM word.

Ports (one clock; reset is asynchronous and active-low, on the port named `rst`):
- `clk` in 1: system clock.
- `rst` in 1: asynchronous, active-low reset.
- `start` in 1: one-cycle pulse; begins clear, then accumulate. Ignored unless in IDLE.
- `in_valid` in 1: input byte valid.
- `in_data` in 8: input byte.
- `in_last` in 1: qualifies the final byte of the stream; sampled with `in_valid && in_ready`.
- `in_ready` out 1: accepting a byte this cycle.
- `histogram` out 32: write data to the SRAM interface.
- `histgram_addr` out 8: bin index to the SRAM interface.
- `hist_r_wr` out 1: 0 = read, 1 = write.
- `sram_req` out 1: request an SRAM transaction.
- `sram_busy` in 1: SRAM interface busy.
- `old_char` in 32: read data from the SRAM interface.
- `total` out 32: number of bytes accepted, saturating.
- `hist_done` out 1: one-cycle pulse when the last byte has been written.
- `hist_busy` out 1: high in every state except IDLE.

## Operation
- States: IDLE, CLR_REQ, CLR_WAIT, GET, RD_REQ, RD_WAIT, WR_REQ, WR_WAIT, DONE.
- IDLE:
  - `start` → CLR_REQ.
  - `start` also sets the clear index to 0 and `total` to 0.
- CLR_REQ:
  - Drives `sram_req=1`, `hist_r_wr=1`, `histogram=0`, `histgram_addr`=clear index.
  - `sram_busy` seen high → CLR_WAIT.
- CLR_WAIT:
  - Waits for `sram_busy` to fall.
  - Index 255 → GET; otherwise index+1 → CLR_REQ.
- GET:
  - `in_ready=1`.
  - On a handshake: latch byte and `in_last`, `total` += 1 (saturating at 32'hFFFF_FFFF) → RD_REQ.
- RD_REQ:
  - `sram_req=1`, `hist_r_wr=0`, addr = latched byte.
  - `sram_busy` high → RD_WAIT.
- RD_WAIT:
  - On the cycle `sram_busy` falls, capture `old_char`.
  - Next value = `old_char`+1, or `old_char` unchanged if it equals 32'hFFFF_FFFF (saturate) → WR_REQ.
- WR_REQ:
  - `sram_req=1`, `hist_r_wr=1`, `histogram` = next value, same addr.
  - `sram_busy` high → WR_WAIT.
- WR_WAIT:
  - `sram_busy` falls → DONE if the latched last flag is set, else GET.
- DONE: `hist_done=1` for one cycle → IDLE.
- `in_ready` is 0 in every state except GET. Bytes arriving during clear stall upstream; none are dropped.
- Outputs `histogram`, `histgram_addr` and `hist_r_wr` are registered and held stable for the whole transaction.

## Timing
- Reset values: state IDLE; `in_ready`, `sram_req`, `hist_done`, `hist_busy` = 0; `histogram`, `histgram_addr`, `total` = 0; `hist_r_wr` = 0.
- Reset asserted mid-transaction: immediately return to IDLE and drop `sram_req`. The SRAM interface completes its own cycle independently.
- One SRAM transaction = 3 cycles of `sram_busy` plus 1 request cycle. Clear takes 256 × 4 = 1024 cycles minimum.
- Per byte: 1 GET + 4 read + 4 write = 9 cycles minimum.
- `sram_req` deasserts on the cycle after `sram_busy` is seen high, so the request is never double-issued.
- `start` during a non-IDLE state: ignored.
- `in_valid` without a handshake: no effect.
- `in_last` on the first byte is legal: that byte is processed, then `hist_done`.
- Repeated identical bytes: each read follows the previous write's completion, so there is no RAW hazard.

## Structure
- Package `t05_pkg`: state enum `hist_state_t`, `HIST_BINS=256`, `CNT_MAX=32'hFFFF_FFFF`.
- One sub-module, `t05_sram_txn`:
  - Holds `sram_req` until the busy rise.
  - Reports done on the busy fall.
  - Shared by the clear, read and write phases.

## Test plan
- Reset low mid-RD_WAIT → all outputs at reset values; `start` afterwards runs a full clear of 256 writes of 0.
- `start`, then stream {0x41, 0x41, 0x42 (last)} → SRAM bin 0x41 = 2, bin 0x42 = 1; `total`=3; one `hist_done` pulse.
- Preload bin 0x07 = 32'hFFFF_FFFF after clear, then send 0x07 (last) → written value stays 32'hFFFF_FFFF.
- `in_valid` held high during clear → `in_ready` stays 0 for all ≥1024 clear cycles; first byte accepted in GET.
- SRAM model with extended busy (5 cycles) → exactly one transaction per request; counts correct.
- Single byte 0xFF with `in_last` → bin 255 = 1; `hist_done` 9 cycles after the handshake under nominal busy.
